// File: rtl/rd_arb_pkg.sv
// rtl/rd_arb_pkg.sv - shared types and constants for the AXI read-channel arbiter
package rd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam int REQ_IFM = 0;
  localparam int REQ_WGT = 1;

  // AXI arsize encoding for a full-width beat of dw bits
  function automatic logic [2:0] axi_size(input int dw);
    return 3'($clog2(dw / 8));
  endfunction

endpackage

// File: rtl/rd_arb_pick.sv
// rtl/rd_arb_pick.sv - two-way winner select, round-robin or fixed priority (RD_ARB_FIXED_PRIO_EN)
module rd_arb_pick
  import rd_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_rr_ptr,
  output logic       o_any,
  output logic       o_grant
);

`ifdef RD_ARB_FIXED_PRIO_EN
  // Pointer is ignored when weights always win
  logic w_unused_ptr;
  assign w_unused_ptr = i_rr_ptr;
`endif

  // Winner: favoured requester if it asks, otherwise the other one
  always_comb begin
    o_any = |i_req;
`ifdef RD_ARB_FIXED_PRIO_EN
    o_grant = i_req[REQ_WGT];
`else
    o_grant = i_req[i_rr_ptr] ? i_rr_ptr : ~i_rr_ptr;
`endif
  end

endmodule

// File: rtl/rd_arbiter.sv
// rtl/rd_arbiter.sv - one-burst-at-a-time AR/R scheduler for IFM and weight buffers (RD_ARB_FIXED_PRIO_EN selects fixed priority)
module rd_arbiter
  import rd_arb_pkg::*;
#(
  parameter int DW   = 32,
  parameter int AW   = 32,
  parameter int LENW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [2*AW-1:0]   req_addr,
  input  logic [2*LENW-1:0] req_len,
  output logic [1:0]        req_ready,
  output logic [DW-1:0]     rd_data,
  output logic [1:0]        rd_valid,
  output logic              rd_last,
  input  logic [1:0]        rd_ready,
  output logic [AW-1:0]     araddr,
  output logic [LENW-1:0]   arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [DW-1:0]     rdata,
  input  logic              rvalid,
  input  logic              rlast,
  output logic              rready,
  output logic              busy,
  output logic              len_err
);

  state_t          r_state;
  state_t          w_state_nxt;
  logic            r_grant;
  logic            r_rr_ptr;
  logic            r_len_err;
  logic [AW-1:0]   r_addr;
  logic [LENW-1:0] r_len;
  logic [LENW:0]   r_beat_cnt;

  logic            w_any;
  logic            w_pick;
  logic            w_accept;
  logic            w_rready;
  logic            w_r_hs;
  logic            w_last_hs;
  logic            w_len_bad;
  logic            w_overrun;

  rd_arb_pick u_pick (
    .i_req    (req_valid),
    .i_rr_ptr (r_rr_ptr),
    .o_any    (w_any),
    .o_grant  (w_pick)
  );

  // No accept while reset is asserted, so a requester never sees a grant that is thrown away
  assign w_accept  = (r_state == IDLE) && w_any && !rst;
  assign w_rready  = rd_ready[r_grant];
  assign w_r_hs    = (r_state == DATA) && rvalid && w_rready;
  assign w_last_hs = w_r_hs && rlast;
  // beat_cnt counts beats before the current one, so a correct last beat sees beat_cnt == len
  assign w_len_bad = (r_beat_cnt != {1'b0, r_len});
  assign w_overrun = w_r_hs && !rlast && (r_beat_cnt > {1'b0, r_len});

  assign araddr  = r_addr;
  assign arlen   = r_len;
  assign arsize  = axi_size(DW);
  assign arburst = AXI_BURST_INCR;
  assign rd_data = rdata;
  assign busy    = (r_state != IDLE);
  assign len_err = r_len_err;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and per-state handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 2'b00;
    arvalid     = 1'b0;
    rready      = 1'b0;
    rd_valid    = 2'b00;
    rd_last     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          req_ready[w_pick] = 1'b1;
          w_state_nxt       = ADDR;
        end
      end
      ADDR: begin
        arvalid = 1'b1;
        if (arready) begin
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        rready            = w_rready;
        rd_valid[r_grant] = rvalid;
        rd_last           = rlast && rvalid;
        if (w_last_hs) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Burst context, beat counting, sticky length check and fairness pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_grant    <= 1'b0;
      r_rr_ptr   <= 1'b0;
      r_len_err  <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_beat_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_grant    <= w_pick;
        r_addr     <= w_pick ? req_addr[AW +: AW] : req_addr[0 +: AW];
        r_len      <= w_pick ? req_len[LENW +: LENW] : req_len[0 +: LENW];
        r_beat_cnt <= '0;
      end
      // Saturate so a runaway slave cannot wrap the counter back into range
      if (w_r_hs && (r_beat_cnt != '1)) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if ((w_last_hs && w_len_bad) || w_overrun) begin
        r_len_err <= 1'b1;
      end
`ifndef RD_ARB_FIXED_PRIO_EN
      if (w_last_hs) begin
        r_rr_ptr <= ~r_grant;
      end
`endif
    end
  end

endmodule
